// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and select encodings for the multicycle control FSM
package ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_DECODE = 3'd2;
    localparam state_t S_EXEC   = 3'd3;
    localparam state_t S_MEM    = 3'd4;
    localparam state_t S_WB     = 3'd5;
    localparam state_t S_TRAP   = 3'd6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } opclass_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    // Classes whose ALU operand B comes from the immediate.
    function automatic logic uses_imm(input opclass_t c);
        return (c == CLS_I) || (c == CLS_LOAD) || (c == CLS_STORE) ||
               (c == CLS_JALR) || (c == CLS_AUIPC);
    endfunction

endpackage

// File: rtl/opcode_class.sv
// rtl/opcode_class.sv - combinational RV32I opcode classifier with legal flag
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   cls,
    output logic       legal
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_OP:     cls = CLS_R;
            OPC_OP_IMM: cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            default:    cls = CLS_ILLEGAL;
        endcase
        legal = (cls != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM with retired-instruction counter
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [1:0]       dmem_size,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       wb_sel,
    output logic             alu_src_imm,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    state_t   state;
    state_t   state_nx;
    opclass_t cls_dec;
    opclass_t cls_q;
    logic     legal_dec;
    logic [1:0] size_q;
    logic     retire;
    logic     unused_bits;

    // The PC register owns RESET_PC; func3[2] only selects sign extension in the datapath.
    assign unused_bits = ^{RESET_PC, func3[2]};

    opcode_class u_opcode_class (
        .opcode (opcode),
        .cls    (cls_dec),
        .legal  (legal_dec)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH:  if (imem_ready) state_nx = S_DECODE;
            S_DECODE: state_nx = legal_dec ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (cls_q == CLS_BRANCH)
                    state_nx = S_FETCH;
                else if (cls_q == CLS_LOAD || cls_q == CLS_STORE)
                    state_nx = S_MEM;
                else
                    state_nx = S_WB;
            end
            S_MEM: begin
                if (dmem_ready)
                    state_nx = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:     state_nx = S_FETCH;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Class and access size are latched once in DECODE so EXEC..WB never re-decode the IR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cls_q   <= CLS_ILLEGAL;
            size_q  <= 2'b00;
            instret <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                cls_q  <= cls_dec;
                size_q <= func3[1:0];
            end
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_size   = 2'b00;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        wb_sel      = WB_ALU;
        alu_src_imm = 1'b0;
        trap        = 1'b0;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                alu_src_imm = uses_imm(cls_q);
                if (cls_q == CLS_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = (cls_q == CLS_STORE);
                dmem_size = size_q;
                if (dmem_ready && cls_q == CLS_STORE) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                case (cls_q)
                    CLS_LOAD: wb_sel = WB_LOAD;
                    CLS_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_IMM; end
                    CLS_JALR: begin wb_sel = WB_PC4; pc_sel = PC_ALU; end
                    CLS_LUI:  wb_sel = WB_IMM;
                    default:  wb_sel = WB_ALU;
                endcase
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       opcode = '0;
    logic [2:0]       func3 = '0;
    logic             branch_taken = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, alu_src_imm, trap;
    logic [1:0]       dmem_size, pc_sel, wb_sel;
    logic [CNT_W-1:0] instret;

    int checks = 0;
    int failures = 0;
    longint model_instret = 0;

    multicycle_ctrl #(.CNT_W(CNT_W), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .func3        (func3),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_size    (dmem_size),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .alu_src_imm  (alu_src_imm),
        .trap         (trap),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    // Per-instruction summary: retire cycle counted from the first FETCH cycle, pulse counts, selects.
    typedef struct packed {
        int lat; int n_ir; int n_ireq; int n_rf; int wb; int pcsel;
        int n_dreq; int dwe; int dsize; int imm; int trp;
    } obs_t;

    typedef struct packed {
        logic [6:0] op; logic [2:0] f3; logic bt; int iw; int dw; obs_t exp;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [13:0] out_vec();
        return {imem_req, ir_we, dmem_req, dmem_we, dmem_size, rf_we, pc_we,
                pc_sel, wb_sel, alu_src_imm, trap};
    endfunction

    function automatic obs_t ob(int lat, int n_rf, int wb, int pcsel, int n_dreq,
                                int dwe, int dsize, int imm, int trp, int n_ireq);
        obs_t o;
        o.lat = lat; o.n_ir = 1; o.n_ireq = n_ireq; o.n_rf = n_rf; o.wb = wb;
        o.pcsel = pcsel; o.n_dreq = n_dreq; o.dwe = dwe; o.dsize = dsize;
        o.imm = imm; o.trp = trp;
        return o;
    endfunction

    // Reference: what one instruction should look like, from the instruction class rules.
    function automatic obs_t model(logic [6:0] op, logic [2:0] f3, logic bt, int iw, int dw);
        logic [1:0] sz;
        sz = f3[1:0];
        case (op)
            7'b0110011: return ob(4 + iw, 1, 0, 0, 0, 0, 0, 0, 0, iw + 1);
            7'b0010011: return ob(4 + iw, 1, 0, 0, 0, 0, 0, 1, 0, iw + 1);
            7'b0110111: return ob(4 + iw, 1, 3, 0, 0, 0, 0, 0, 0, iw + 1);
            7'b0010111: return ob(4 + iw, 1, 0, 0, 0, 0, 0, 1, 0, iw + 1);
            7'b1101111: return ob(4 + iw, 1, 2, 1, 0, 0, 0, 0, 0, iw + 1);
            7'b1100111: return ob(4 + iw, 1, 2, 2, 0, 0, 0, 1, 0, iw + 1);
            7'b0000011: return ob(5 + iw + dw, 1, 1, 0, dw + 1, 0, int'(sz), 1, 0, iw + 1);
            7'b0100011: return ob(4 + iw + dw, 0, 0, 0, dw + 1, 1, int'(sz), 1, 0, iw + 1);
            7'b1100011: return ob(3 + iw, 0, 0, int'(bt), 0, 0, 0, 0, 0, iw + 1);
            default:    return ob(0, 0, 0, 0, 0, 0, 0, 0, 1, iw + 1);
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        opcode = '0; func3 = '0; branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", out_vec(), 0);
        chk("reset_instret", instret, 0);
        @(negedge clk);
        rst_n = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("idle_outputs", out_vec(), 0);
        model_instret = 0;
    endtask

    // Memory responders wait iw/dw request cycles; ready toggles randomly when nothing is requested.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic bt,
                             input int iw, input int dw, output obs_t o,
                             output longint ins0, output longint ins_end);
        int icnt, dcnt, tcnt;
        bit done;
        o = '0; icnt = 0; dcnt = 0; tcnt = 0; done = 0; ins0 = 0; ins_end = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            opcode = op; func3 = f3; branch_taken = bt;
            imem_ready = imem_req ? (icnt >= iw) : 1'($urandom_range(0, 1));
            dmem_ready = dmem_req ? (dcnt >= dw) : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 1) ins0 = instret;
            ins_end = instret;
            if (imem_req) begin icnt++; o.n_ireq++; end
            if (dmem_req) begin
                dcnt++; o.n_dreq++; o.dwe = int'(dmem_we); o.dsize = int'(dmem_size);
            end
            if (ir_we) o.n_ir++;
            if (rf_we) begin o.n_rf++; o.wb = int'(wb_sel); end
            if (alu_src_imm) o.imm = 1;
            if (trap) begin o.trp = 1; tcnt++; end
            if (pc_we) begin o.lat = cyc; o.pcsel = int'(pc_sel); done = 1; end
            if (tcnt >= 4) done = 1;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [6:0] op, input logic [2:0] f3,
                                 input logic bt, input int iw, input int dw, input obs_t e);
        obs_t o;
        longint ins0, ins_end;
        run_instr(op, f3, bt, iw, dw, o, ins0, ins_end);
        chk({tag, ".instret_pre"}, ins0, model_instret);
        chk({tag, ".lat"}, o.lat, e.lat);
        chk({tag, ".n_ir_we"}, o.n_ir, e.n_ir);
        chk({tag, ".n_imem_req"}, o.n_ireq, e.n_ireq);
        chk({tag, ".n_rf_we"}, o.n_rf, e.n_rf);
        chk({tag, ".wb_sel"}, o.wb, e.wb);
        chk({tag, ".pc_sel"}, o.pcsel, e.pcsel);
        chk({tag, ".n_dmem_req"}, o.n_dreq, e.n_dreq);
        chk({tag, ".dmem_we"}, o.dwe, e.dwe);
        chk({tag, ".dmem_size"}, o.dsize, e.dsize);
        chk({tag, ".alu_src_imm"}, o.imm, e.imm);
        chk({tag, ".trap"}, o.trp, e.trp);
        if (e.trp != 0) begin
            chk({tag, ".instret_frozen"}, ins_end, model_instret);
            do_reset();
        end else begin
            model_instret++;
        end
    endtask

    function automatic bit is_legal(logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                          7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};
    endfunction

    vec_t vecs[10];
    logic [6:0] legal_ops[9];

    initial begin
        vecs[0] = '{op: 7'b0010011, f3: 3'd0, bt: 1'b0, iw: 0, dw: 0, exp: ob(4, 1, 0, 0, 0, 0, 0, 1, 0, 1)};
        vecs[1] = '{op: 7'b0000011, f3: 3'd2, bt: 1'b0, iw: 0, dw: 3, exp: ob(8, 1, 1, 0, 4, 0, 2, 1, 0, 1)};
        vecs[2] = '{op: 7'b1100011, f3: 3'd0, bt: 1'b1, iw: 0, dw: 0, exp: ob(3, 0, 0, 1, 0, 0, 0, 0, 0, 1)};
        vecs[3] = '{op: 7'b1100011, f3: 3'd0, bt: 1'b0, iw: 0, dw: 0, exp: ob(3, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[4] = '{op: 7'b0100011, f3: 3'd0, bt: 1'b0, iw: 0, dw: 0, exp: ob(4, 0, 0, 0, 1, 1, 0, 1, 0, 1)};
        vecs[5] = '{op: 7'b1100111, f3: 3'd0, bt: 1'b0, iw: 0, dw: 0, exp: ob(4, 1, 2, 2, 0, 0, 0, 1, 0, 1)};
        vecs[6] = '{op: 7'b1101111, f3: 3'd0, bt: 1'b1, iw: 1, dw: 0, exp: ob(5, 1, 2, 1, 0, 0, 0, 0, 0, 2)};
        vecs[7] = '{op: 7'b0110111, f3: 3'd0, bt: 1'b0, iw: 0, dw: 0, exp: ob(4, 1, 3, 0, 0, 0, 0, 0, 0, 1)};
        vecs[8] = '{op: 7'b0110011, f3: 3'd1, bt: 1'b0, iw: 2, dw: 0, exp: ob(6, 1, 0, 0, 0, 0, 0, 0, 0, 3)};
        vecs[9] = '{op: 7'b0000000, f3: 3'd0, bt: 1'b0, iw: 0, dw: 0, exp: ob(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                      7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};

        do_reset();
        for (int i = 0; i < 10; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].f3, vecs[i].bt,
                          vecs[i].iw, vecs[i].dw, vecs[i].exp);

        for (int i = 0; i < 80; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic bt;
            int iw, dw;
            if ($urandom_range(0, 11) == 0) begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            f3 = 3'($urandom);
            bt = 1'($urandom);
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            run_and_check($sformatf("rnd%0d", i), op, f3, bt, iw, dw, model(op, f3, bt, iw, dw));
        end

        // Reset pulled during a MEM wait: request must drop before the next clock edge.
        do_reset();
        opcode = 7'b0000011; func3 = 3'd2;
        @(negedge clk); imem_ready = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midmem.dmem_req_before", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midmem.dmem_req_async_drop", dmem_req, 0);
        chk("midmem.instret_reset", instret, 0);
        @(negedge clk);
        dmem_ready = 1'b1; rst_n = 1'b1;
        #1;
        chk("midmem.idle_outputs", out_vec(), 0);
        @(negedge clk);
        dmem_ready = 1'b0; imem_ready = 1'b0;
        #1;
        chk("midmem.fetch_after", {imem_req, rf_we, dmem_req}, 3'b100);
        chk("midmem.instret_after", instret, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
